// File: rtl/fp_result_packer_if.sv
// Handshake bundle between the mantissa multiplier, the result packer and the
// result register. Widths follow the selected IEEE format.
interface fp_result_packer_if #(
  parameter int IS_DOUBLE = 0
);
  localparam int F     = IS_DOUBLE ? 52 : 23;
  localparam int E     = IS_DOUBLE ? 11 : 8;
  localparam int WIDTH = IS_DOUBLE ? 64 : 32;

  logic                in_valid;
  logic                in_ready;
  logic                in_sign;
  logic signed [E+1:0] in_exp;
  logic [2*F+1:0]      in_mant;
  logic [1:0]          in_special;
  logic                out_valid;
  logic                out_ready;
  logic [WIDTH-1:0]    result;
  logic                overflow;
  logic                underflow;
  logic                inexact;

  // packer view
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
    output in_ready, out_valid, result, overflow, underflow, inexact
  );

  // multiplier / result register view
  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_special, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, inexact
  );
endinterface

// File: rtl/fp_result_packer.sv
// Result packer: iterative normalize, round-to-nearest-even and IEEE pack of an
// unpacked product. One normalization step per cycle, valid/ready both sides.
module fp_result_packer #(
  parameter int IS_DOUBLE = 0
) (
  input  logic              clk,
  input  logic              rst,
  fp_result_packer_if.slave bus
);
  localparam int F     = IS_DOUBLE ? 52 : 23;
  localparam int E     = IS_DOUBLE ? 11 : 8;
  localparam int WIDTH = IS_DOUBLE ? 64 : 32;
  localparam int MW    = 2*F + 2;
  // Two extra bits over the input exponent leave headroom for the final
  // right shift and the rounding carry without wrapping.
  localparam int XW    = E + 4;

  localparam logic signed [XW-1:0] EXP_ONE = XW'(1);
  localparam logic signed [XW-1:0] EXP_MIN = XW'(-(F + 2));
  localparam logic signed [XW-1:0] EXP_INF = XW'((1 << E) - 1);
  localparam logic [WIDTH-1:0]     QNAN    = {1'b0, {E{1'b1}}, 1'b1, {(F-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

  state_t               state, state_nxt;
  logic                 wsign;
  logic signed [XW-1:0] wexp;
  logic [MW-1:0]        wmant;
  logic                 wsticky;
  logic [WIDTH-1:0]     result_q;
  logic                 overflow_q, underflow_q, inexact_q;
  logic                 out_valid_q;

  logic                 is_special, force_zero, shift_right, shift_left;
  logic [WIDTH-1:0]     special_result;

  logic [F:0]           kept, kept_rnd;
  logic [F+1:0]         sum;
  logic                 guard, rsticky, inc;
  logic signed [XW-1:0] exp_rnd;
  logic [E-1:0]         exp_field;
  logic                 rnd_overflow, rnd_inexact, rnd_underflow;
  logic [WIDTH-1:0]     rnd_result;

  // Classify the incoming product and choose this cycle's normalization step.
  always_comb begin
    is_special  = (bus.in_special != 2'b00) || (bus.in_mant == '0);
    force_zero  = wexp < EXP_MIN;
    shift_right = !force_zero && (wmant[MW-1] || wexp < EXP_ONE);
    shift_left  = !force_zero && !shift_right && !wmant[2*F] && wexp > EXP_ONE;
  end

  // Canonical results for the operand-classification shortcuts.
  always_comb begin
    case (bus.in_special)
      2'b11:   special_result = QNAN;
      2'b10:   special_result = {bus.in_sign, {E{1'b1}}, {F{1'b0}}};
      default: special_result = {bus.in_sign, {(WIDTH-1){1'b0}}};
    endcase
  end

  // Round to nearest-even on the normalized working register and pack.
  always_comb begin
    kept    = wmant[2*F:F];
    guard   = wmant[F-1];
    rsticky = (|wmant[F-2:0]) | wsticky;
    inc     = guard & (rsticky | kept[0]);
    sum     = {1'b0, kept} + {{(F+1){1'b0}}, inc};
    if (sum[F+1]) begin
      kept_rnd = sum[F+1:1];
      exp_rnd  = wexp + EXP_ONE;
    end else begin
      kept_rnd = sum[F:0];
      exp_rnd  = wexp;
    end
    // A hidden bit of 0 only happens at exp==1, i.e. a denormal; a denormal
    // that rounds into the hidden bit naturally picks up exponent field 1.
    exp_field     = kept_rnd[F] ? exp_rnd[E-1:0] : '0;
    rnd_overflow  = exp_rnd >= EXP_INF;
    rnd_inexact   = guard | rsticky | rnd_overflow;
    rnd_underflow = (guard | rsticky) & ~kept[F];
    if (rnd_overflow) rnd_result = {wsign, {E{1'b1}}, {F{1'b0}}};
    else              rnd_result = {wsign, exp_field, kept_rnd[F-1:0]};
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid) state_nxt = is_special ? DONE : NORM;
      NORM:    if (!force_zero && !shift_right && !shift_left) state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    if (out_valid_q && bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: accept only when idle, present the registered result.
  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = out_valid_q;
    bus.result    = result_q;
    bus.overflow  = overflow_q;
    bus.underflow = underflow_q;
    bus.inexact   = inexact_q;
  end

  // Working register and result register updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      wsign       <= 1'b0;
      wexp        <= '0;
      wmant       <= '0;
      wsticky     <= 1'b0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      inexact_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          wsign   <= bus.in_sign;
          wexp    <= {{(XW-E-2){bus.in_exp[E+1]}}, bus.in_exp};
          wmant   <= bus.in_mant;
          wsticky <= 1'b0;
          if (is_special) begin
            result_q    <= special_result;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            inexact_q   <= 1'b0;
          end
        end
        NORM: begin
          if (force_zero) begin
            // Far below the smallest denormal: everything becomes sticky.
            wmant   <= '0;
            wsticky <= wsticky | (|wmant);
            wexp    <= EXP_ONE;
          end else if (shift_right) begin
            wmant   <= wmant >> 1;
            wsticky <= wsticky | wmant[0];
            wexp    <= wexp + EXP_ONE;
          end else if (shift_left) begin
            wmant   <= wmant << 1;
            wexp    <= wexp - EXP_ONE;
          end
        end
        ROUND: begin
          result_q    <= rnd_result;
          overflow_q  <= rnd_overflow;
          underflow_q <= rnd_underflow;
          inexact_q   <= rnd_inexact;
        end
        default: ;
      endcase
    end
  end

  // out_valid rises one cycle after entering DONE and drops after the handshake.
  always_ff @(posedge clk) begin
    if (rst)                                 out_valid_q <= 1'b0;
    else if (state == DONE && !out_valid_q)  out_valid_q <= 1'b1;
    else if (out_valid_q && bus.out_ready)   out_valid_q <= 1'b0;
  end
endmodule

// File: tb/tb_fp_result_packer.sv
// Bench for fp_result_packer (binary32): directed cases plus random products
// compared against an exact-arithmetic rounding model.
module tb_fp_result_packer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  fp_result_packer_if #(.IS_DOUBLE(0)) bus();
  fp_result_packer #(.IS_DOUBLE(0)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // Exact reference: value = m * 2^(ex-127-46), rounded RNE onto the binary32
  // grid. Returns {overflow, underflow, inexact, result}.
  function automatic logic [34:0] ref_model(input logic s, input int ex,
                                            input logic [47:0] m, input logic [1:0] sp);
    logic [63:0] mm, mq;
    int          msb, e, qe, k, field;
    logic        g, rest, inx;
    if (sp == 2'b11) return {3'b000, 32'h7FC00000};
    if (sp == 2'b10) return {3'b000, s, 8'hFF, 23'h0};
    if (sp == 2'b01 || m == 48'h0) return {3'b000, s, 31'h0};
    mm  = {16'h0, m};
    msb = 0;
    for (int i = 0; i < 48; i++) if (m[i]) msb = i;
    e  = ex - 127 + msb - 46;             // unbiased exponent of the exact value
    qe = ((e < -126) ? -126 : e) - 23;    // weight of the result LSB
    k  = qe + 173 - ex;                   // right shift onto that grid
    if (k <= 0) begin
      mq = mm << (-k); g = 1'b0; rest = 1'b0;
    end else begin
      mq   = mm >> k;
      g    = ((mm >> (k - 1)) & 64'd1) != 64'd0;
      rest = (mm & ((64'd1 << (k - 1)) - 64'd1)) != 64'd0;
    end
    inx = g | rest;
    if (g && (rest || mq[0])) mq = mq + 64'd1;
    if (mq == (64'd1 << 24)) begin mq = mq >> 1; qe = qe + 1; end
    field = mq[23] ? qe + 150 : 0;
    if (field >= 255) return {3'b101, s, 8'hFF, 23'h0};
    return {1'b0, inx && (e < -126), inx, s, field[7:0], mq[22:0]};
  endfunction

  // Push one product through, check latency (if exp_lat>=0), result, flags and
  // the handshake; hold keeps out_ready low that many cycles with out_valid up.
  task automatic run_op(input string tag, input logic s, input int ex, input logic [47:0] m,
                        input logic [1:0] sp, input logic [34:0] want, input int exp_lat,
                        input int hold);
    int lat;
    bus.out_ready = (hold == 0);
    @(negedge clk);
    bus.in_sign = s; bus.in_exp = 10'(ex); bus.in_mant = m; bus.in_special = sp;
    bus.in_valid = 1'b1;
    check({tag, "_accept_ready"}, bus.in_ready, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      check({tag, "_busy_ready"}, bus.in_ready, 0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_out_valid"}, bus.out_valid, 1);
    if (exp_lat >= 0) check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_result"}, {bus.overflow, bus.underflow, bus.inexact, bus.result}, want);
    check({tag, "_excl"}, bus.in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, bus.out_valid, 1);
      check({tag, "_hold_ready"}, bus.in_ready, 0);
      check({tag, "_hold_result"}, {bus.overflow, bus.underflow, bus.inexact, bus.result}, want);
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_drop_valid"}, bus.out_valid, 0);
    check({tag, "_idle_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    logic        s, seen;
    int          ex, msb;
    logic [47:0] m;
    logic [63:0] r;
    logic [1:0]  sp;

    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0;
    bus.in_mant = '0; bus.in_special = 2'b00; bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_result", {bus.overflow, bus.underflow, bus.inexact, bus.result}, 0);
    @(negedge clk) rst = 1'b0;

    // directed cases
    run_op("mul_1p5", 0, 127, 48'h9 << 44, 2'b00, {3'b000, 32'h40100000}, 4, 0);
    run_op("tie_even", 0, 127, (48'd1 << 46) | (48'd1 << 22), 2'b00, {3'b001, 32'h3F800000}, -1, 0);
    run_op("tie_up", 0, 127, (48'd1 << 46) | (48'd1 << 23) | (48'd1 << 22), 2'b00,
           {3'b001, 32'h3F800002}, -1, 0);
    run_op("left_norm", 0, 130, 48'd1 << 44, 2'b00, {3'b000, 32'h40000000}, 5, 0);
    run_op("ovf_pos", 0, 254, 48'd1 << 47, 2'b00, {3'b101, 32'h7F800000}, -1, 0);
    run_op("ovf_neg", 1, 254, 48'd1 << 47, 2'b00, {3'b101, 32'hFF800000}, -1, 0);
    run_op("denorm", 0, -1, 48'd1 << 46, 2'b00, {3'b000, 32'h00200000}, -1, 0);
    run_op("flush", 0, -40, 48'd1 << 46, 2'b00, {3'b011, 32'h00000000}, -1, 0);
    run_op("nan_hold", 1, 127, 48'd1 << 46, 2'b11, {3'b000, 32'h7FC00000}, 1, 5);
    run_op("inf_neg", 1, 5, 48'd1 << 46, 2'b10, {3'b000, 32'hFF800000}, 1, 0);
    run_op("zero_mant", 1, 127, 48'd0, 2'b00, {3'b000, 32'h80000000}, 1, 0);

    // reset while normalizing aborts the operation
    @(negedge clk);
    bus.in_sign = 0; bus.in_exp = 10'(300); bus.in_mant = 48'd1; bus.in_special = 2'b00;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_in_ready", bus.in_ready, 1);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      seen = seen | bus.out_valid;
    end
    check("abort_no_result", seen, 0);
    run_op("after_abort", 0, 127, 48'h9 << 44, 2'b00, {3'b000, 32'h40100000}, 4, 0);

    // randomized products against the reference model
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0:       ex = int'($urandom_range(100, 160));
        1:       ex = int'($urandom_range(0, 1023)) - 512;
        2:       ex = int'($urandom_range(0, 40)) - 30;
        default: ex = int'($urandom_range(240, 262));
      endcase
      msb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 47)) : int'($urandom_range(46, 47));
      r = {$urandom(), $urandom()};
      m = r[47:0] & ((48'd1 << msb) - 48'd1) | (48'd1 << msb);
      if ($urandom_range(0, 3) == 0) m[21:0] = 22'h0;
      if ($urandom_range(0, 31) == 0) m = 48'h0;
      sp = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      s  = 1'($urandom_range(0, 1));
      run_op("rand", s, ex, m, sp, ref_model(s, ex, m, sp), -1,
             ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
